// File: rtl/divider_cfg_master_if.sv
// Configuration handshake and 3-wire serial port of the PLL divider programmer.
// The master modport is the programmer's view; the slave modport is the
// view of the upstream requester / serial-port observer.
interface divider_cfg_master_if #(
  parameter int N_W = 10,
  parameter int A_W = 13
) ();
  logic           cfg_valid;
  logic           cfg_ready;
  logic [N_W-1:0] cfg_n;
  logic [A_W-1:0] cfg_a;
  logic           cfg_done;
  logic           spi_sclk;
  logic           spi_ncs;
  logic           spi_mosi;

  modport master (
    input  cfg_valid, cfg_n, cfg_a,
    output cfg_ready, cfg_done, spi_sclk, spi_ncs, spi_mosi
  );

  modport slave (
    output cfg_valid, cfg_n, cfg_a,
    input  cfg_ready, cfg_done, spi_sclk, spi_ncs, spi_mosi
  );
endinterface

// File: rtl/divider_cfg_master.sv
// SPI master that programs the PLL N/A divider pair with one 32-bit frame
// {6'b0, N, 3'b0, A}, MSB first, and keeps a shadow of the last values sent.
// All outputs are registered from the next-state decode. The done cycle is
// the first IDLE cycle, so between back-to-back frames ncs stays high for the
// GAP_CYC gap cycles plus that done/accept cycle.
module divider_cfg_master #(
  parameter int HALF_DIV = 6,
  parameter int GAP_CYC  = 12,
  parameter int N_W      = 10,
  parameter int A_W      = 13
) (
  input  logic                 clk_ref_12M,
  input  logic                 rst_n,
  divider_cfg_master_if.master bus,
  output logic                 busy,
  output logic [N_W-1:0]       cur_n,
  output logic [A_W-1:0]       cur_a
);

  localparam int MAXC  = (HALF_DIV > GAP_CYC) ? HALF_DIV : GAP_CYC;
  localparam int CNT_W = $clog2(MAXC) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       bit_reg, bit_next;
  logic [31:0]      word_reg, word_next;
  logic [N_W-1:0]   n_reg, n_next;
  logic [A_W-1:0]   a_reg, a_next;

  logic           sclk_reg, sclk_next;
  logic           ncs_reg, ncs_next;
  logic           mosi_reg, mosi_next;
  logic           ready_reg, ready_next;
  logic           done_reg, done_next;
  logic           busy_reg, busy_next;
  logic [N_W-1:0] cur_n_reg, cur_n_next;
  logic [A_W-1:0] cur_a_reg, cur_a_next;

  logic        accept;
  logic        in_frame;
  logic [31:0] frame;

  assign accept = bus.cfg_valid & ready_reg;

  // Assemble the frame word from the request fields; unused bits stay zero.
  always_comb begin
    frame              = '0;
    frame[16 +: N_W]   = bus.cfg_n;
    frame[0 +: A_W]    = bus.cfg_a;
  end

  // State, counters, frame shifter and registered outputs.
  always_ff @(posedge clk_ref_12M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      word_reg  <= '0;
      n_reg     <= '0;
      a_reg     <= '0;
      sclk_reg  <= 1'b0;
      ncs_reg   <= 1'b1;
      mosi_reg  <= 1'b0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      cur_n_reg <= '0;
      cur_a_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      word_reg  <= word_next;
      n_reg     <= n_next;
      a_reg     <= a_next;
      sclk_reg  <= sclk_next;
      ncs_reg   <= ncs_next;
      mosi_reg  <= mosi_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
      cur_n_reg <= cur_n_next;
      cur_a_reg <= cur_a_next;
    end
  end

  // Next-state decode: half-period timing, bit counting and word shifting.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    word_next  = word_reg;
    n_next     = n_reg;
    a_next     = a_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
          cnt_next   = '0;
          bit_next   = '0;
          word_next  = frame;
          n_next     = bus.cfg_n;
          a_next     = bus.cfg_a;
        end
      end
      SETUP: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HIGH: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          bit_next = bit_reg + 6'd1;
          if (bit_reg == 6'd31) begin
            state_next = HOLD;
          end else begin
            state_next = LOW;
            word_next  = {word_reg[30:0], 1'b0};
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LOW: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    in_frame   = (state_next == SETUP) || (state_next == HIGH) ||
                 (state_next == LOW)   || (state_next == HOLD);
    ncs_next   = ~in_frame;
    sclk_next  = (state_next == HIGH);
    mosi_next  = in_frame & word_next[31];
    ready_next = (state_next == IDLE);
    done_next  = (state_reg == GAP) && (state_next == IDLE);
    busy_next  = (state_next != IDLE) || done_next;
    cur_n_next = done_next ? n_reg : cur_n_reg;
    cur_a_next = done_next ? a_reg : cur_a_reg;
  end

  assign bus.spi_sclk  = sclk_reg;
  assign bus.spi_ncs   = ncs_reg;
  assign bus.spi_mosi  = mosi_reg;
  assign bus.cfg_ready = ready_reg;
  assign bus.cfg_done  = done_reg;
  assign busy          = busy_reg;
  assign cur_n         = cur_n_reg;
  assign cur_a         = cur_a_reg;

endmodule
